// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
//   Shared types and constants for the pipelined CPU front end and the stages
//   that talk to it. The program counter is word addressed.
//
//   PC_W      program-counter / instruction-memory address width
//   INSTR_W   instruction width
//   RESET_PC  PC value loaded at reset
//   pc_t      PC type. Decode and execute use it too, so redirect targets and
//             presented PCs always agree in width.
//   instr_t   instruction word type
//   fetch_state_t  fetch front-end state: RUN or HALTED
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int PC_W    = 5;
  localparam int INSTR_W = 32;

  typedef logic [PC_W-1:0]    pc_t;
  typedef logic [INSTR_W-1:0] instr_t;

  localparam pc_t RESET_PC = '0;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  // Sequential next PC. It wraps modulo 2^PC_W, with no flag.
  function automatic pc_t pc_inc(input pc_t pc);
    return pc + pc_t'(1);
  endfunction

endpackage

// File: rtl/fetch_hold.sv
// ---------------------------------------------------------------------------
// fetch_hold
//   Single-entry hold buffer for the fetch stage. The instruction memory is
//   read every cycle, so its output moves on during a stall. In the first
//   stall cycle this buffer captures the instruction that is being presented.
//   It then supplies that instruction until stall falls. This keeps if_instr
//   stable for the whole stall.
//
//   Ports
//     clk      rising-edge clock
//     rst_n    asynchronous active-low reset
//     stall_i  hazard-unit stall
//     clear_i  drop any held entry (redirect / halt / halted)
//     rdata_i  instruction-memory read data
//     instr_o  instruction to present: the held entry while holding, else rdata_i
// ---------------------------------------------------------------------------
module fetch_hold
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_i,
  input  logic               clear_i,
  input  logic [INSTR_W-1:0] rdata_i,
  output logic [INSTR_W-1:0] instr_o
);

  instr_t hold_q;
  instr_t hold_d;
  logic   active_q;
  logic   active_d;

  always_comb begin
    hold_d   = hold_q;
    active_d = active_q;
    if (clear_i) begin
      active_d = 1'b0;
    end else if (stall_i) begin
      // Capture only on the first stall cycle. Later cycles would see the
      // memory output for the following PC.
      if (!active_q) begin
        hold_d   = rdata_i;
        active_d = 1'b1;
      end
    end else begin
      // The cycle in which stall falls still presents the held entry.
      // Decode consumes it then, so release at this edge.
      active_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q   <= '0;
      active_q <= 1'b0;
    end else begin
      hold_q   <= hold_d;
      active_q <= active_d;
    end
  end

  assign instr_o = active_q ? hold_q : rdata_i;

endmodule

// File: rtl/fetch.sv
// ---------------------------------------------------------------------------
// fetch
//   Instruction-fetch stage. It owns the word-addressed PC and drives a
//   synchronous instruction memory: data arrives one cycle after the address.
//   It presents (if_pc, if_instr, if_valid) to decode.
//
//   Next-PC priority while in RUN:
//     1. redirect_valid from execute. Load the target, squash the in-flight
//        request and clear the hold buffer.
//     2. halt_in from decode. Freeze the front end permanently.
//     3. stall from the hazard unit. Hold the PC and the outputs.
//     4. Otherwise advance the PC by 1.
//   In HALTED the stage ignores redirect and stall. Only reset leaves HALTED.
//
//   Optional build macro:
//     FETCH_PERF_EN  fetch_count counts delivered instructions, meaning cycles
//                    with if_valid & ~stall. It saturates at 0xFFFF. Without
//                    the macro there is no counter and fetch_count reads 0.
//
//   Ports
//     clk, rst_n         clock, asynchronous active-low reset
//     stall              hazard-unit stall
//     redirect_valid/pc  taken jump/branch target from execute
//     halt_in            decode holds a halt instruction
//     imem_addr          instruction-memory read address (= PC)
//     imem_rdata         instruction-memory data (one cycle after address)
//     if_valid/pc/instr  instruction presented to decode
//     halted             front end stopped
//     fetch_count        delivered-instruction count
// ---------------------------------------------------------------------------
module fetch
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               halt_in,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [PC_W-1:0]    if_pc,
  output logic [INSTR_W-1:0] if_instr,
  output logic               halted,
  output logic [15:0]        fetch_count
);

  fetch_state_t state_q;
  fetch_state_t state_d;
  pc_t          pc_q;
  pc_t          pc_d;
  pc_t          if_pc_q;
  pc_t          if_pc_d;
  logic         req_q;
  logic         req_d;

  logic         running;
  logic         hold_clear;
  instr_t       hold_instr;

  assign running = (state_q == RUN);

  // -------------------------------------------------------------------------
  // Next-state / next-PC
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if_pc_d = if_pc_q;
    req_d   = req_q;
    if (running) begin
      if (redirect_valid) begin
        // The memory read issued this cycle is wrong-path. Clear req_q so
        // that it appears as the single bubble, and ignore stall.
        pc_d  = redirect_pc;
        req_d = 1'b0;
      end else if (halt_in) begin
        state_d = HALTED;
        req_d   = 1'b0;
      end else if (stall) begin
        // Hold PC, presented PC and valid.
      end else begin
        // Issue pc_q: it becomes the presented PC once its data returns.
        pc_d    = pc_inc(pc_q);
        if_pc_d = pc_q;
        req_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      if_pc_q <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if_pc_q <= if_pc_d;
      req_q   <= req_d;
    end
  end

  // -------------------------------------------------------------------------
  // Stall hold buffer
  // -------------------------------------------------------------------------
  assign hold_clear = !running || redirect_valid || halt_in;

  fetch_hold u_hold (
    .clk     (clk),
    .rst_n   (rst_n),
    .stall_i (stall),
    .clear_i (hold_clear),
    .rdata_i (imem_rdata),
    .instr_o (hold_instr)
  );

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign imem_addr = pc_q;
  assign if_valid  = req_q && running;
  assign if_pc     = if_pc_q;
  // Gate with valid so that reset and bubbles present a clean zero, whatever
  // the memory is returning.
  assign if_instr  = if_valid ? hold_instr : '0;
  assign halted    = (state_q == HALTED);

  // -------------------------------------------------------------------------
  // Delivered-instruction counter
  // -------------------------------------------------------------------------
`ifdef FETCH_PERF_EN
  logic [15:0] count_q;
  logic [15:0] count_d;

  always_comb begin
    count_d = count_q;
    if (if_valid && !stall && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 16'h0000;
    end else begin
      count_q <= count_d;
    end
  end

  assign fetch_count = count_q;
`else
  assign fetch_count = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch.sv
// ---------------------------------------------------------------------------
// tb_fetch
//   Directed bench for the fetch stage. It holds a 32-word synchronous
//   instruction memory filled with a known pattern. Each scenario task drives
//   inputs just after a rising edge and checks the outputs in the same cycle.
// ---------------------------------------------------------------------------
module tb_fetch;
  import cpu_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               stall;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic               halt_in;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata = '0;
  logic               if_valid;
  logic [PC_W-1:0]    if_pc;
  logic [INSTR_W-1:0] if_instr;
  logic               halted;
  logic [15:0]        fetch_count;

  logic [31:0] mem [0:31];
  int checks   = 0;
  int failures = 0;

  fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_in        (halt_in),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= mem[imem_addr];

  function automatic logic [31:0] instr_of(input int i);
    return 32'hA500_0000 ^ (32'(i) * 32'h0001_2345);
  endfunction

  // Expected counter value after n delivered instructions, for this build.
  function automatic logic [15:0] exp_cnt(input int n);
`ifdef FETCH_PERF_EN
    return 16'(n);
`else
    return 16'(n) & 16'h0000;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in the first cycle after reset release.
  task automatic do_reset();
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt_in = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt_in = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    $display("reset: valid=%0b pc=%0d instr=%h halted=%0b cnt=%0d addr=%0d",
             if_valid, if_pc, if_instr, halted, fetch_count, imem_addr);
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %0b expected 0", if_valid); end
    checks++; if (if_pc !== '0) begin failures++; $display("FAIL reset_pc got %0d expected 0", if_pc); end
    checks++; if (if_instr !== '0) begin failures++; $display("FAIL reset_instr got %h expected 0", if_instr); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got %0b expected 0", halted); end
    checks++; if (fetch_count !== 16'h0) begin failures++; $display("FAIL reset_count got %0d expected 0", fetch_count); end
    checks++; if (imem_addr !== RESET_PC) begin failures++; $display("FAIL reset_addr got %0d expected %0d", imem_addr, RESET_PC); end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    do_reset();
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL seq_first_valid got %0b expected 0", if_valid); end
    checks++; if (imem_addr !== RESET_PC) begin failures++; $display("FAIL seq_first_addr got %0d expected %0d", imem_addr, RESET_PC); end
    for (int i = 0; i < 6; i++) begin
      tick();
      $display("seq: valid=%0b pc=%0d instr=%h", if_valid, if_pc, if_instr);
      checks++; if (if_valid !== 1'b1) begin failures++; $display("FAIL seq_valid[%0d] got %0b expected 1", i, if_valid); end
      checks++; if (if_pc !== pc_t'(i)) begin failures++; $display("FAIL seq_pc[%0d] got %0d expected %0d", i, if_pc, i); end
      checks++; if (if_instr !== instr_of(i)) begin failures++; $display("FAIL seq_instr[%0d] got %h expected %h", i, if_instr, instr_of(i)); end
      checks++; if (fetch_count !== exp_cnt(i)) begin failures++; $display("FAIL seq_count[%0d] got %0d expected %0d", i, fetch_count, exp_cnt(i)); end
    end
  endtask

  task automatic test_wrap();
    int exp_pc [4];
    exp_pc[0] = 30; exp_pc[1] = 31; exp_pc[2] = 0; exp_pc[3] = 1;
    do_reset();
    redirect_valid = 1'b1; redirect_pc = pc_t'(30);
    tick();
    redirect_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      $display("wrap: valid=%0b pc=%0d instr=%h", if_valid, if_pc, if_instr);
      checks++; if (if_valid !== 1'b1) begin failures++; $display("FAIL wrap_valid[%0d] got %0b expected 1", k, if_valid); end
      checks++; if (if_pc !== pc_t'(exp_pc[k])) begin failures++; $display("FAIL wrap_pc[%0d] got %0d expected %0d", k, if_pc, exp_pc[k]); end
      checks++; if (if_instr !== instr_of(exp_pc[k])) begin failures++; $display("FAIL wrap_instr[%0d] got %h expected %h", k, if_instr, instr_of(exp_pc[k])); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    repeat (5) tick();
    stall = 1'b1;
    for (int s = 0; s < 3; s++) begin
      $display("stall: valid=%0b pc=%0d instr=%h addr=%0d", if_valid, if_pc, if_instr, imem_addr);
      checks++; if (if_valid !== 1'b1) begin failures++; $display("FAIL stall_valid[%0d] got %0b expected 1", s, if_valid); end
      checks++; if (if_pc !== pc_t'(4)) begin failures++; $display("FAIL stall_pc[%0d] got %0d expected 4", s, if_pc); end
      checks++; if (if_instr !== instr_of(4)) begin failures++; $display("FAIL stall_instr[%0d] got %h expected %h", s, if_instr, instr_of(4)); end
      checks++; if (imem_addr !== pc_t'(5)) begin failures++; $display("FAIL stall_addr[%0d] got %0d expected 5", s, imem_addr); end
      checks++; if (fetch_count !== exp_cnt(4)) begin failures++; $display("FAIL stall_count[%0d] got %0d expected %0d", s, fetch_count, exp_cnt(4)); end
      tick();
    end
    stall = 1'b0;
    // Stall released: the held instruction is consumed in this cycle.
    checks++; if (if_pc !== pc_t'(4)) begin failures++; $display("FAIL stall_rel_pc got %0d expected 4", if_pc); end
    checks++; if (if_instr !== instr_of(4)) begin failures++; $display("FAIL stall_rel_instr got %h expected %h", if_instr, instr_of(4)); end
    for (int n = 5; n < 7; n++) begin
      tick();
      $display("stall_after: valid=%0b pc=%0d instr=%h", if_valid, if_pc, if_instr);
      checks++; if (if_pc !== pc_t'(n)) begin failures++; $display("FAIL stall_next_pc got %0d expected %0d", if_pc, n); end
      checks++; if (if_instr !== instr_of(n)) begin failures++; $display("FAIL stall_next_instr got %h expected %h", if_instr, instr_of(n)); end
      checks++; if (fetch_count !== exp_cnt(n)) begin failures++; $display("FAIL stall_next_count got %0d expected %0d", fetch_count, exp_cnt(n)); end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    repeat (4) tick();
    checks++; if (if_pc !== pc_t'(3)) begin failures++; $display("FAIL redir_pre_pc got %0d expected 3", if_pc); end
    redirect_valid = 1'b1; redirect_pc = pc_t'(7);
    tick();
    redirect_valid = 1'b0;
    $display("redirect bubble: valid=%0b addr=%0d", if_valid, imem_addr);
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL redir_bubble got %0b expected 0", if_valid); end
    checks++; if (imem_addr !== pc_t'(7)) begin failures++; $display("FAIL redir_addr got %0d expected 7", imem_addr); end
    for (int n = 7; n < 9; n++) begin
      tick();
      $display("redirect: valid=%0b pc=%0d instr=%h", if_valid, if_pc, if_instr);
      checks++; if (if_valid !== 1'b1) begin failures++; $display("FAIL redir_valid got %0b expected 1", if_valid); end
      checks++; if (if_pc !== pc_t'(n)) begin failures++; $display("FAIL redir_pc got %0d expected %0d", if_pc, n); end
      checks++; if (if_instr !== instr_of(n)) begin failures++; $display("FAIL redir_instr got %h expected %h", if_instr, instr_of(n)); end
    end
  endtask

  task automatic test_redirect_priority();
    do_reset();
    repeat (3) tick();
    redirect_valid = 1'b1; redirect_pc = pc_t'(12); halt_in = 1'b1; stall = 1'b1;
    tick();
    redirect_valid = 1'b0; halt_in = 1'b0; stall = 1'b0;
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL prio_halted got %0b expected 0", halted); end
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL prio_bubble got %0b expected 0", if_valid); end
    checks++; if (imem_addr !== pc_t'(12)) begin failures++; $display("FAIL prio_addr got %0d expected 12", imem_addr); end
    tick();
    $display("prio: valid=%0b pc=%0d halted=%0b", if_valid, if_pc, halted);
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL prio_halted2 got %0b expected 0", halted); end
    checks++; if (if_valid !== 1'b1) begin failures++; $display("FAIL prio_valid got %0b expected 1", if_valid); end
    checks++; if (if_pc !== pc_t'(12)) begin failures++; $display("FAIL prio_pc got %0d expected 12", if_pc); end
    checks++; if (if_instr !== instr_of(12)) begin failures++; $display("FAIL prio_instr got %h expected %h", if_instr, instr_of(12)); end
  endtask

  task automatic test_halt();
    do_reset();
    repeat (10) tick();
    checks++; if (if_pc !== pc_t'(9)) begin failures++; $display("FAIL halt_pre_pc got %0d expected 9", if_pc); end
    halt_in = 1'b1;
    tick();
    halt_in = 1'b0;
    $display("halt: halted=%0b valid=%0b cnt=%0d", halted, if_valid, fetch_count);
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_halted got %0b expected 1", halted); end
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL halt_valid got %0b expected 0", if_valid); end
    checks++; if (fetch_count !== exp_cnt(10)) begin failures++; $display("FAIL halt_count got %0d expected %0d", fetch_count, exp_cnt(10)); end
    redirect_valid = 1'b1; redirect_pc = pc_t'(3); stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      $display("halted: halted=%0b valid=%0b addr=%0d cnt=%0d", halted, if_valid, imem_addr, fetch_count);
      checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_hold[%0d] got %0b expected 1", c, halted); end
      checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL halt_hold_valid[%0d] got %0b expected 0", c, if_valid); end
      checks++; if (imem_addr !== pc_t'(10)) begin failures++; $display("FAIL halt_hold_addr[%0d] got %0d expected 10", c, imem_addr); end
      checks++; if (fetch_count !== exp_cnt(10)) begin failures++; $display("FAIL halt_hold_count[%0d] got %0d expected %0d", c, fetch_count, exp_cnt(10)); end
      stall = ~stall;
    end
    redirect_valid = 1'b0; stall = 1'b0;
    // Reset while halted returns outputs immediately.
    rst_n = 1'b0;
    #1;
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL halt_reset_halted got %0b expected 0", halted); end
    checks++; if (if_pc !== '0) begin failures++; $display("FAIL halt_reset_pc got %0d expected 0", if_pc); end
    checks++; if (fetch_count !== 16'h0) begin failures++; $display("FAIL halt_reset_count got %0d expected 0", fetch_count); end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_halt_in_stall();
    do_reset();
    repeat (3) tick();
    stall = 1'b1;
    tick();
    halt_in = 1'b1;
    tick();
    halt_in = 1'b0;
    $display("halt_in_stall: halted=%0b valid=%0b", halted, if_valid);
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL hstall_halted got %0b expected 1", halted); end
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL hstall_valid got %0b expected 0", if_valid); end
    stall = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    repeat (4) tick();
    stall = 1'b1;
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    $display("reset_mid_stall: valid=%0b pc=%0d instr=%h", if_valid, if_pc, if_instr);
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL rstall_valid got %0b expected 0", if_valid); end
    checks++; if (if_pc !== '0) begin failures++; $display("FAIL rstall_pc got %0d expected 0", if_pc); end
    checks++; if (if_instr !== '0) begin failures++; $display("FAIL rstall_instr got %h expected 0", if_instr); end
    checks++; if (imem_addr !== RESET_PC) begin failures++; $display("FAIL rstall_addr got %0d expected %0d", imem_addr, RESET_PC); end
    stall = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = instr_of(i);
    test_reset();
    test_sequential();
    test_wrap();
    test_stall();
    test_redirect();
    test_redirect_priority();
    test_halt();
    test_halt_in_stall();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
